// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_rate, input int baud);
    return clk_rate / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO carrying a data word plus a side-band last flag.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_last,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_last,
  output logic             empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CNTW-1:0] count_reg;
  logic            wr_ok;
  logic            rd_ok;
  logic [WIDTH:0]  head;

  assign full  = (count_reg == CNTW'(DEPTH));
  assign empty = (count_reg == '0);

  // A full FIFO rejects the push even if a pop happens in the same cycle.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= {din_last, din};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head is gated while empty so stale or uninitialised storage never shows.
  assign head      = mem[rd_ptr_reg];
  assign dout      = empty ? '0 : head[WIDTH-1:0];
  assign dout_last = !empty && head[WIDTH];

endmodule

// File: rtl/uart_rx.sv
// UART deserialiser: 2-flop synchroniser, mid-bit sampling FSM, LSB-first shift register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CLK_RATE = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_line,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_done,
  output logic             frame_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int IW           = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);

  logic             rx_meta_reg;
  logic             rx_sync_reg;
  rx_state_t        state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [IW-1:0]    bit_idx_reg;
  logic [WIDTH-1:0] shift_reg;
  logic             rx_done_reg;
  logic             frame_err_reg;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx_line;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      rx_done_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_done_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!rx_sync_reg) begin
            state_reg <= START;
            cnt_reg   <= '0;
          end
        end
        START: begin
          // Re-check the start bit at its midpoint to reject short glitches.
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            if (!rx_sync_reg) begin
              state_reg   <= DATA;
              bit_idx_reg <= '0;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= WIDTH'({rx_sync_reg, shift_reg} >> 1);
            if (bit_idx_reg == IDX_LAST) begin
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (cnt_reg == BIT_LAST) begin
            cnt_reg <= '0;
            if (rx_sync_reg) begin
              rx_done_reg <= 1'b1;
              state_reg   <= IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= WAIT_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_sync_reg) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rx_data   = shift_reg;
  assign rx_done   = rx_done_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: rtl/uart_rx_fifo_axis.sv
// UART receiver buffered in a FIFO and presented as an AXI-Stream master with terminator framing.
module uart_rx_fifo_axis
  import uart_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 8,
  parameter int               CLK_RATE  = 50000000,
  parameter int               BAUD      = 115200,
  parameter logic [WIDTH-1:0] LAST_CHAR = WIDTH'(8'h0A)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  output logic [WIDTH-1:0] m_axis_data,
  output logic             m_axis_valid,
  output logic             m_axis_last,
  input  logic             m_axis_ready,
  output logic             frame_err,
  output logic             overflow
);

  logic [WIDTH-1:0] rx_data;
  logic             rx_done;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overflow_reg;

  uart_rx #(
    .WIDTH    (WIDTH),
    .CLK_RATE (CLK_RATE),
    .BAUD     (BAUD)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_line   (uart_rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (rx_done),
    .din       (rx_data),
    .din_last  (rx_data == LAST_CHAR),
    .full      (fifo_full),
    .rd_en     (m_axis_valid && m_axis_ready),
    .dout      (m_axis_data),
    .dout_last (m_axis_last),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= rx_done && fifo_full;
    end
  end

  assign m_axis_valid = !fifo_empty;
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo_axis.sv
// Self-checking bench: table-driven and random UART frames against a queue-based reference.
module tb_uart_rx_fifo_axis;

  localparam int         DEPTH     = 8;
  localparam int         CLK_RATE  = 50000000;
  localparam int         BAUD      = 115200;
  localparam int         CPB       = CLK_RATE / BAUD;
  localparam int         HALF      = CPB / 2;
  localparam logic [7:0] LAST_CHAR = 8'h0A;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rx = 1'b1;
  logic       m_axis_ready = 1'b0;
  logic [7:0] m_axis_data;
  logic       m_axis_valid;
  logic       m_axis_last;
  logic       frame_err;
  logic       overflow;

  uart_rx_fifo_axis dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_last  (m_axis_last),
    .m_axis_ready (m_axis_ready),
    .frame_err    (frame_err),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } vec_t;

  vec_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_ovf = 0;
  int   ferr_seen = 0;
  int   ovf_seen = 0;
  int   beats_seen = 0;
  logic hold_pend = 1'b0;
  logic [7:0] hold_data;
  logic hold_last;
  logic rand_on;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference: every good frame enters the queue unless DEPTH words are already waiting.
  task automatic model_push(input logic [7:0] d, input logic last);
    vec_t e;
    if (exp_q.size() >= DEPTH) begin
      exp_ovf++;
    end else begin
      e.data = d;
      e.last = last;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      hold_pend = 1'b0;
    end else begin
      if (frame_err) ferr_seen++;
      if (overflow) ovf_seen++;
      if (hold_pend) begin
        check("hold_valid", m_axis_valid, 1);
        check("hold_word", {m_axis_last, m_axis_data}, {hold_last, hold_data});
      end
      if (m_axis_valid && m_axis_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %0h want no beat", m_axis_data);
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          check("beat_data", m_axis_data, e.data);
          check("beat_last", m_axis_last, e.last);
          $display("beat data=%0h last=%0b", m_axis_data, m_axis_last);
        end
      end
      hold_pend = m_axis_valid && !m_axis_ready;
      hold_data = m_axis_data;
      hold_last = m_axis_last;
    end
  end

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_head(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic push,
                            input logic last);
    send_head(d);
    if (push) model_push(d, last);
    drive_bit(stop);
    $display("frame sent data=%0h stop=%0b", d, stop);
  endtask

  initial begin
    repeat (99000) @(posedge clk);
    $display("FAIL watchdog: got no finish want finish within cycle budget");
    $fatal(1);
  end

  initial begin
    vec_t tbl [3];
    int   nz;
    int   lat;
    int   b0;
    logic [7:0] d;

    tbl[0] = '{8'h41, 1'b0};
    tbl[1] = '{8'h0A, 1'b1};
    tbl[2] = '{8'h0B, 1'b0};

    // Reset and idle
    nz = 0;
    repeat (5) begin
      @(negedge clk);
      if ({m_axis_data, m_axis_valid, m_axis_last, frame_err, overflow} !== 12'h0) nz++;
    end
    check("reset_outputs_zero", nz, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    nz = 0;
    repeat (1000) begin
      @(negedge clk);
      if ({m_axis_data, m_axis_valid, m_axis_last, frame_err, overflow} !== 12'h0) nz++;
    end
    check("idle_outputs_zero", nz, 0);
    @(posedge clk); #1;

    // Single frame with latency: start detect through synchroniser (3) + half bit + rx_done and write (2)
    m_axis_ready = 1'b1;
    b0 = beats_seen;
    send_head(8'h55);
    model_push(8'h55, 1'b0);
    uart_rx = 1'b1;
    lat = 0;
    for (int i = 1; i <= CPB; i++) begin
      @(negedge clk);
      if (m_axis_valid && lat == 0) lat = i;
    end
    @(posedge clk); #1;
    drive_bit(1'b1);
    check("single_latency", lat, HALF + 5);
    check("single_beats", beats_seen - b0, 1);
    check("single_ferr", ferr_seen, 0);
    check("single_ovf", ovf_seen, 0);

    // Back-to-back table frames including the terminator
    b0 = beats_seen;
    for (int i = 0; i < 3; i++) send_frame(tbl[i].data, 1'b1, 1'b1, tbl[i].last);
    drive_bit(1'b1);
    check("table_beats", beats_seen - b0, 3);
    check("table_drained", exp_q.size(), 0);

    // Glitch, then framing error, then a held-low line
    b0 = beats_seen;
    uart_rx = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("glitch_ferr", ferr_seen, 1);
    check("glitch_beats", beats_seen - b0, 0);
    check("glitch_valid", m_axis_valid, 0);

    // Overflow under backpressure
    m_axis_ready = 1'b0;
    b0 = beats_seen;
    for (int i = 1; i <= 9; i++) begin
      d = 8'(i);
      send_frame(d, 1'b1, 1'b1, d == LAST_CHAR);
      check("ovf_progress", ovf_seen, exp_ovf);
    end
    check("ovf_head_data", m_axis_data, 8'h01);
    check("ovf_head_valid", m_axis_valid, 1);
    m_axis_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("ovf_drain_beats", beats_seen - b0, 8);
    check("ovf_drain_valid", m_axis_valid, 0);
    check("ovf_drain_queue", exp_q.size(), 0);

    // Reset during the data bits of 0xA5
    b0 = beats_seen;
    d = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_valid", m_axis_valid, 0);
    for (int i = 3; i < 7; i++) drive_bit(d[i]);
    rst = 1'b1;
    drive_bit(d[7]);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("midreset_no_beat", beats_seen - b0, 0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b1);
    check("midreset_next_beat", beats_seen - b0, 1);

    // Random frames with random backpressure
    b0 = beats_seen;
    rand_on = 1'b1;
    fork
      begin
        for (int f = 0; f < 2; f++) begin
          d = ($urandom_range(0, 1) == 1) ? LAST_CHAR : 8'($urandom_range(0, 255));
          send_frame(d, 1'b1, 1'b1, d == LAST_CHAR);
          repeat ($urandom_range(0, 100)) @(posedge clk);
          #1;
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          m_axis_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_axis_ready = 1'b1;
    drive_bit(1'b1);
    check("rand_beats", beats_seen - b0, 2);
    check("rand_drained", exp_q.size(), 0);
    check("rand_valid", m_axis_valid, 0);

    check("total_frame_err", ferr_seen, 1);
    check("total_overflow", ovf_seen, exp_ovf);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_axis.md
Name: uart_rx_fifo_axis

Overview:
- Receive-side counterpart of the UART transmit path.
- Deserialises an asynchronous UART line (8N1 by default) and buffers received words in a synchronous FIFO.
- Presents the words as an AXI-Stream master.
- Asserts m_axis_last on a configurable terminator character so downstream logic can frame packets.
- Sits between the board-level RX pin and any AXI-Stream consumer.

Parameters:
- WIDTH, 8, data bits per UART frame and AXI-Stream tdata width.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CLK_RATE, 50000000, clk frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- LAST_CHAR, 8'h0A, received value that sets m_axis_last on that word.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset. One clock; reset is asynchronous and active-low.
- uart_rx  input  1  asynchronous serial line; idles high.
- m_axis_data  output  WIDTH  head-of-FIFO word.
- m_axis_valid  output  1  FIFO not empty.
- m_axis_last  output  1  head word equals LAST_CHAR.
- m_axis_ready  input  1  consumer accepts the word.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overflow  output  1  one-cycle pulse when a good word is dropped because the FIFO is full.

Behaviour:
- CLKS_PER_BIT = CLK_RATE/BAUD, integer division (434 at defaults). HALF_BIT = CLKS_PER_BIT/2.
- Bit counter width is $clog2(CLKS_PER_BIT).
- uart_rx passes through a 2-flop synchroniser, reset value 1. Only the synchronised signal is used.
- Reset values:
  - All outputs 0.
  - FSM in IDLE; FIFO empty; counters 0.
  - Reset asserted mid-frame aborts the frame. No partial word is written.
- FSM states (enum rx_state_t):
  - IDLE: stay until sync line == 0, then go to START with counter cleared.
  - START: count to HALF_BIT-1 and sample. If 0, go to DATA with bit index 0. If 1 (glitch), go back to IDLE with nothing written.
  - DATA: every CLKS_PER_BIT cycles, sample into shift register LSB-first. After WIDTH samples, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - If 1: rx_done for 1 cycle, then IDLE. The FSM returns immediately at mid-stop so back-to-back frames are caught.
    - If 0: frame_err for 1 cycle, word discarded, go to WAIT_IDLE.
  - WAIT_IDLE: stay until sync line == 1, then IDLE. This prevents a break condition from retriggering.
- FIFO write:
  - On rx_done with FIFO not full, write the word plus last flag (word == LAST_CHAR).
  - If full, drop the word and pulse overflow.
  - A pop in the same cycle does not rescue a full-FIFO push.
- FIFO read:
  - Show-ahead. m_axis_valid = !empty.
  - m_axis_data/m_axis_last reflect the head entry combinationally from FIFO storage.
  - Pop when valid && ready.
  - Data and last stay stable while valid && !ready.
- Pointers wrap modulo DEPTH.
- Occupancy counter width $clog2(DEPTH+1). Push and pop in the same cycle leave the count unchanged.
- Latency: the word is visible on m_axis_valid 2 cycles after the STOP sample (rx_done register, then FIFO write).

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum.
  - Function clks_per_bit(CLK_RATE, BAUD).
- Sub-module uart_rx holds the synchroniser, FSM, shift register and frame_err. Its outputs are rx_data, rx_done, frame_err.
- Top level instantiates uart_rx and sync_fifo (WIDTH, DEPTH). The last flag goes through the din_last/dout_last path.
- Top level adds the overflow and AXI-Stream glue.

Test Plan:
- Reset and idle:
  - Hold rst=0 for 5 cycles, line high.
  - All outputs 0 during reset and for 1000 cycles after release.
- Single frame:
  - Send 0x55 at 434 clk/bit with m_axis_ready=1.
  - One beat: data 0x55, last 0.
  - valid asserts 2 cycles after the mid-stop sample.
  - No frame_err or overflow.
- Terminator:
  - Send 0x41, 0x0A back-to-back.
  - Two beats: (0x41, last 0), then (0x0A, last 1).
- Glitch and framing error:
  - Drive the line low for 100 cycles, then send a frame with stop bit 0.
  - No beat for the glitch.
  - Exactly one frame_err pulse; FIFO stays empty.
  - Line held low 3 bit-times afterwards produces no further frames.
- Overflow with backpressure:
  - m_axis_ready=0, DEPTH=8, send 0x01..0x09.
  - Exactly one overflow pulse on the 9th byte.
  - valid held with data 0x01 stable throughout.
  - Raise ready: beats 0x01..0x08 in order, then valid=0.
- Reset mid-frame:
  - Assert rst during the DATA bits of 0xA5.
  - No beat produced.
  - After release, the next frame 0x3C is received correctly.
